// File: rtl/shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// shared_bus_arbiter
//
// Round-robin arbiter for the shared global-memory/device bus. Each core
// raises its bit of core_request for a non-local access and stalls until its
// bit of core_grant (shared_ready) is high. Grants are combinational, so a
// requesting core is serviced in the same cycle it wins. Each grant covers
// exactly one bus cycle, and the winning core gets lowest priority next time.
//
// Parameters:
//   NUM_CORES    number of requesting cores, 2..16
//   INDEX_WIDTH  width of an encoded core index (derived)
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   core_request   bit i = shared_request from core i
//   core_grant     one-hot (or zero) grant, drives shared_ready of each core
//   bus_active     some core owns the bus this cycle
//   grant_index    encoded index of the current owner, 0 when idle
//   grant_valid_l  bus_active delayed by one cycle
//   grant_index_l  grant_index delayed by one cycle (read-data attribution)
//
// Optional build macro SHARED_ARB_STATS_EN adds:
//   stat_grant_count       cycles with a grant (wraps at 2^32)
//   stat_contention_count  cycles with two or more requests (wraps at 2^32)
// ---------------------------------------------------------------------------
module shared_bus_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int INDEX_WIDTH = $clog2(NUM_CORES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CORES-1:0]   core_request,
  output logic [NUM_CORES-1:0]   core_grant,
  output logic                   bus_active,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_valid_l,
  output logic [INDEX_WIDTH-1:0] grant_index_l
`ifdef SHARED_ARB_STATS_EN
  ,
  output logic [31:0]            stat_grant_count,
  output logic [31:0]            stat_contention_count
`endif
);

  localparam logic [INDEX_WIDTH:0]   NUM_W    = (INDEX_WIDTH+1)'(NUM_CORES);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_CORES - 1);

  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] winner;
  logic [INDEX_WIDTH-1:0] next_ptr;
  logic [INDEX_WIDTH:0]   cand;
  logic                   found;

  // Search from ptr upward, wrapping modulo NUM_CORES. The extra bit on cand
  // keeps ptr+k from overflowing before the explicit wrap, so non-power-of-2
  // core counts never produce an index >= NUM_CORES.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment;
    // a path that leaves one unassigned would infer a latch.
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = {1'b0, ptr} + (INDEX_WIDTH+1)'(k);
      if (cand >= NUM_W) begin
        cand = cand - NUM_W;
      end
      if (!found && core_request[cand[INDEX_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = cand[INDEX_WIDTH-1:0];
      end
    end
  end

  // Reset forces the bus idle in the same cycle, dropping any grant in flight.
  always_comb begin
    core_grant  = '0;
    bus_active  = 1'b0;
    grant_index = '0;
    if (!reset && found) begin
      core_grant[winner] = 1'b1;
      bus_active         = 1'b1;
      grant_index        = winner;
    end
  end

  // The winner drops to lowest priority on the next cycle.
  always_comb begin
    next_ptr = (winner == LAST_IDX) ? '0 : winner + INDEX_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      grant_valid_l <= 1'b0;
      grant_index_l <= '0;
    end else begin
      if (bus_active) begin
        ptr <= next_ptr;
      end
      grant_valid_l <= bus_active;
      grant_index_l <= grant_index;
    end
  end

`ifdef SHARED_ARB_STATS_EN
  logic multi_req;

  // Clearing the lowest set bit leaves something only if two or more bits
  // were set, i.e. at least one requester went ungranted.
  always_comb begin
    multi_req = |(core_request & (core_request - NUM_CORES'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grant_count      <= '0;
      stat_contention_count <= '0;
    end else begin
      if (bus_active) begin
        stat_grant_count <= stat_grant_count + 32'd1;
      end
      if (multi_req) begin
        stat_contention_count <= stat_contention_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_bus_arbiter
//
// Drives directed and random request vectors into shared_bus_arbiter and
// compares every output each cycle against a behavioural round-robin model
// (priority pointer plus modular search). Directed phases also compare the
// DUT against hand-written grant sequences. Build with SHARED_ARB_STATS_EN
// to cover the statistics counters as well.
// ---------------------------------------------------------------------------
module tb_shared_bus_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  core_request;
  logic [N-1:0]  core_grant;
  logic          bus_active;
  logic [IW-1:0] grant_index;
  logic          grant_valid_l;
  logic [IW-1:0] grant_index_l;
`ifdef SHARED_ARB_STATS_EN
  logic [31:0]   stat_grant_count;
  logic [31:0]   stat_contention_count;
`endif

  always #5 clk = ~clk;

  shared_bus_arbiter #(.NUM_CORES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .core_request  (core_request),
    .core_grant    (core_grant),
    .bus_active    (bus_active),
    .grant_index   (grant_index),
    .grant_valid_l (grant_valid_l),
    .grant_index_l (grant_index_l)
`ifdef SHARED_ARB_STATS_EN
    ,
    .stat_grant_count      (stat_grant_count),
    .stat_contention_count (stat_contention_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_ptr = 0;
  int          m_gv  = 0;
  int          m_gi  = 0;
  int          wait_cnt [N];
  logic [31:0] m_cnt_g = '0;
  logic [31:0] m_cnt_c = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: apply inputs, compare at the falling edge, advance the
  // model past the rising edge.
  task automatic step(input logic [N-1:0] req, input bit rst,
                      input bit use_lit, input logic [N-1:0] lit);
    int w;
    bit act;
    core_request = req;
    reset        = rst;
    act = 1'b0;
    w   = 0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!act && req[j]) begin
          act = 1'b1;
          w   = j;
        end
      end
    end

    @(negedge clk);
    check("core_grant",    32'(core_grant),    act ? (32'd1 << w) : 32'd0);
    check("bus_active",    32'(bus_active),    32'(act));
    check("grant_index",   32'(grant_index),   act ? 32'(w) : 32'd0);
    check("grant_valid_l", 32'(grant_valid_l), 32'(m_gv));
    check("grant_index_l", 32'(grant_index_l), 32'(m_gi));
`ifdef SHARED_ARB_STATS_EN
    check("stat_grant_count",      stat_grant_count,      m_cnt_g);
    check("stat_contention_count", stat_contention_count, m_cnt_c);
`endif
    if (use_lit) begin
      check("directed_grant", 32'(core_grant), 32'(lit));
    end

    // A continuously requesting core must not go N cycles without a grant.
    for (int i = 0; i < N; i++) begin
      if (rst || !req[i] || (act && w == i)) begin
        wait_cnt[i] = 0;
      end else begin
        wait_cnt[i]++;
        check("starvation_bound", 32'(wait_cnt[i] < N), 32'd1);
      end
    end

    @(posedge clk);
    #1;
    if (rst) begin
      m_ptr   = 0;
      m_gv    = 0;
      m_gi    = 0;
      m_cnt_g = '0;
      m_cnt_c = '0;
    end else begin
      m_gv = int'(act);
      m_gi = act ? w : 0;
      if (act) begin
        m_ptr   = (w + 1) % N;
        m_cnt_g = m_cnt_g + 32'd1;
      end
      if ($countones(req) >= 2) begin
        m_cnt_c = m_cnt_c + 32'd1;
      end
    end
  endtask

  initial begin
    logic [N-1:0] seq_all [8];
    logic [N-1:0] hold;
    seq_all = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    core_request = '0;
    reset        = 1'b1;

    // Reset, then idle: nothing granted, delayed valid stays low.
    step(4'b1111, 1'b1, 1'b1, 4'b0000);
    step(4'b1111, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b1, 4'b0000);

    // All cores requesting: strict rotation from core 0.
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b1, seq_all[i]);

    // Core 1 wins, moving ptr to 2; then 0011 wraps to core 0, then core 1.
    step(4'b0010, 1'b0, 1'b1, 4'b0010);
    step(4'b0011, 1'b0, 1'b1, 4'b0001);
    step(4'b0011, 1'b0, 1'b1, 4'b0010);

    // Lone requester keeps winning; ptr ends at 3, so 1111 next picks core 3.
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b1, 4'b0100);
    step(4'b1111, 1'b0, 1'b1, 4'b1000);

    // Reset mid-rotation drops the grant; first grant afterwards is core 0.
    step(4'b1111, 1'b0, 1'b1, 4'b0001);
    step(4'b1111, 1'b1, 1'b1, 4'b0000);
    step(4'b1111, 1'b0, 1'b1, 4'b0001);
    check("post_reset_valid_l", 32'(grant_valid_l), 32'd1);

    // Statistics scenario: 0110 for 4 cycles, idle for 2.
    step(4'b0000, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) step(4'b0110, 1'b0, 1'b1, (i % 2 == 0) ? 4'b0010 : 4'b0100);
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
`ifdef SHARED_ARB_STATS_EN
    check("stat_grant_lit",      stat_grant_count,      32'd4);
    check("stat_contention_lit", stat_contention_count, 32'd4);
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0), 1'b0, '0);
    end

    // Some cores hold their request continuously to exercise the bound.
    for (int blk = 0; blk < 5; blk++) begin
      hold = N'($urandom_range(1, 15));
      for (int i = 0; i < 200; i++) begin
        step(hold | N'($urandom_range(0, 15)), 1'b0, 1'b0, '0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
